// File: rtl/delay_valid_var.sv
// delay_valid_var
//
// Purpose:
//   Delay line for WIDTH-bit data words that carry a valid tag. Words move
//   through DEPTH register stages, one stage per enabled clock edge. The
//   output tap is chosen at runtime, so the delay can be anywhere from
//   0 (combinational bypass) to DEPTH enabled edges. The line stalls with
//   en=0 and empties on flush, so it can follow the main pipeline it
//   shadows (writeback tags, hazard bookkeeping).
//
// Parameters:
//   WIDTH  data bits per entry (>= 1)
//   DEPTH  number of register stages, i.e. maximum delay (>= 1)
//   SEL_W  derived width of the tap select, $clog2(DEPTH+1)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears every stage
//   en         advance enable; 0 = every stage holds its value
//   flush      synchronous clear of every stage; lower priority than reset,
//              higher than en
//   sel        tap select, in enabled cycles of delay (0..DEPTH).
//              Values above DEPTH are clamped to DEPTH.
//   in         data in
//   in_valid   valid tag for in
//   out        data at the selected tap
//   out_valid  valid tag at the selected tap
//   count      (UTIL_DELAY_VALID_COUNT_EN only) registered number of stages
//              whose valid tag is set, counted over all stages regardless
//              of sel
//
// Configuration:
//   UTIL_DELAY_VALID_COUNT_EN  when defined, adds the count output and the
//                              counter that drives it. When undefined, the
//                              port and its logic do not exist.

module delay_valid_var #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 2,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
`ifdef UTIL_DELAY_VALID_COUNT_EN
    output logic [SEL_W-1:0] count,
`endif
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    // Stage k holds the word sampled k enabled edges ago.
    // Index 1 is the newest stage and index DEPTH the oldest.
    logic [WIDTH-1:0] stage_d [1:DEPTH];
    logic             stage_v [1:DEPTH];

    // Tap select after clamping out-of-range values to the last stage.
    logic [SEL_W-1:0] tap_sel;

    // Shift register. Reset and flush both empty the line and drop the word
    // presented in that cycle. A stall holds every stage, so the word keeps
    // its position and the delay counts only enabled edges.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_d[k] <= '0;
                stage_v[k] <= 1'b0;
            end
        end else if (en) begin
            stage_d[1] <= in;
            stage_v[1] <= in_valid;
            for (int k = 2; k <= DEPTH; k++) begin
                stage_d[k] <= stage_d[k-1];
                stage_v[k] <= stage_v[k-1];
            end
        end
    end

    // A select above DEPTH is only possible when DEPTH+1 is not a power of
    // two. It reads the oldest stage.
    always_comb begin
        tap_sel = sel;
        if (sel > SEL_W'(DEPTH)) begin
            tap_sel = SEL_W'(DEPTH);
        end
    end

    // Output mux. sel=0 bypasses the line completely, so it follows the
    // input even during a stall. No stored state depends on sel, so
    // changing it takes effect in the same cycle.
    always_comb begin
        out       = in;
        out_valid = in_valid;
        for (int k = 1; k <= DEPTH; k++) begin
            if (tap_sel == SEL_W'(k)) begin
                out       = stage_d[k];
                out_valid = stage_v[k];
            end
        end
    end

`ifdef UTIL_DELAY_VALID_COUNT_EN
    // Occupancy counter updated on the same edge as the stages.
    // A valid word entering stage 1 adds one and a valid word leaving the
    // last stage subtracts one. When both happen on the same edge, the
    // count does not change. The maximum value is DEPTH, which always fits
    // in SEL_W bits.
    logic [SEL_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_q <= '0;
        end else if (en) begin
            case ({in_valid, stage_v[DEPTH]})
                2'b10:   count_q <= count_q + SEL_W'(1);
                2'b01:   count_q <= count_q - SEL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
`endif

endmodule
